unified_mem_arbiter: RTL and testbench

Shares one single-ported unified memory between the pipelined RISC-V core's instruction-fetch (IF) and memory-access (MEM) stages. It accepts one request from each stage, grants the memory to one of them, and runs a req/ack transaction to the memory. It returns the read data with a one-cycle valid pulse and drives stall signals back to the pipeline control. It sits between the IF/MEM stages and the unified memory model, replacing the separate instruction/data memories.

---
 rtl/riscv_mem_pkg.sv | 20 ++
 rtl/arb_grant_sel.sv | 32 +++
 rtl/unified_mem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared types and defaults for the unified IF/MEM memory arbiter.
package riscv_mem_pkg;

    localparam int unsigned DEF_ADDR_W     = 64;
    localparam int unsigned DEF_DATA_W     = 64;
    localparam int unsigned DEF_STARVE_MAX = 4;
    localparam int unsigned INSTR_W        = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_e;

endpackage

// File: rtl/arb_grant_sel.sv
// Grant priority decision between the IF and MEM requesters.
// With ARB_STARVE_GUARD_EN defined, a starve hit lets IF win over MEM.
module arb_grant_sel
    import riscv_mem_pkg::*;
(
    input  logic   if_req,
    input  logic   mem_req,
    input  logic   starve_hit,
    output owner_e owner_c
);

`ifdef ARB_STARVE_GUARD_EN
    always_comb begin
        owner_c = OWN_MEM;
        if (if_req && (!mem_req || starve_hit)) begin
            owner_c = OWN_IF;
        end
    end
`else
    logic unused_starve_hit;
    assign unused_starve_hit = starve_hit;

    // MEM holds the older instruction, so it always wins a tie.
    always_comb begin
        owner_c = OWN_MEM;
        if (if_req && !mem_req) begin
            owner_c = OWN_IF;
        end
    end
`endif

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported unified memory between IF and MEM stages.
// Optional IF starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module unified_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [INSTR_W-1:0]  if_rdata,
    output logic                if_valid,
    input  logic                mem_req,
    input  logic                mem_we,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_valid,
    output logic                stall_if,
    output logic                stall_mem,
    output logic                m_req,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_ack
);

    state_e               state_q, state_d;
    owner_e               owner_q, owner_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 we_q, we_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic                 m_req_q, m_req_d;
    logic                 if_valid_q, if_valid_d;
    logic                 mem_valid_q, mem_valid_d;
    logic [INSTR_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]    mem_rdata_q, mem_rdata_d;

    owner_e               grant_c;
    logic                 starve_hit_c;
    logic                 any_req_c;

    assign any_req_c = if_req | mem_req;

    arb_grant_sel u_grant_sel (
        .if_req     (if_req),
        .mem_req    (mem_req),
        .starve_hit (starve_hit_c),
        .owner_c    (grant_c)
    );

`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    assign starve_hit_c = (starve_cnt_q == CNT_W'(STARVE_MAX));

    // Counts MEM grants taken while IF waits; saturates at STARVE_MAX.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if ((state_q == IDLE) && any_req_c) begin
            if (grant_c == OWN_IF) begin
                starve_cnt_d = '0;
            end else if (if_req && !starve_hit_c) begin
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    localparam int unsigned unused_starve_max = STARVE_MAX;

    assign starve_hit_c = 1'b0;
`endif

    // Next-state and registered-output logic for the IDLE/BUSY/DONE transaction.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        m_req_d     = m_req_q;
        if_valid_d  = 1'b0;
        mem_valid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;

        case (state_q)
            IDLE: begin
                if (any_req_c) begin
                    owner_d = grant_c;
                    m_req_d = 1'b1;
                    state_d = BUSY;
                    if (grant_c == OWN_MEM) begin
                        addr_d  = mem_addr;
                        we_d    = mem_we;
                        wdata_d = mem_wdata;
                    end else begin
                        addr_d  = if_addr & ~ADDR_W'(3);
                        we_d    = 1'b0;
                        wdata_d = '0;
                    end
                end
            end
            BUSY: begin
                if (m_ack) begin
                    m_req_d = 1'b0;
                    state_d = DONE;
                    if (owner_q == OWN_IF) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = addr_q[2] ? m_rdata[INSTR_W +: INSTR_W]
                                               : m_rdata[0 +: INSTR_W];
                    end else begin
                        mem_valid_d = 1'b1;
                        mem_rdata_d = m_rdata;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                m_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            m_req_q     <= 1'b0;
            if_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            m_req_q     <= m_req_d;
            if_valid_q  <= if_valid_d;
            mem_valid_q <= mem_valid_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign m_req     = m_req_q;
    assign m_we      = we_q;
    assign m_addr    = addr_q;
    assign m_wdata   = wdata_q;
    assign if_valid  = if_valid_q;
    assign if_rdata  = if_rdata_q;
    assign mem_valid = mem_valid_q;
    assign mem_rdata = mem_rdata_q;

    // Stalls follow the live requests, released by the registered valid pulse.
    assign stall_if  = if_req & ~if_valid_q;
    assign stall_mem = mem_req & ~mem_valid_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: directed IF/MEM traffic against a memory model.
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [63:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_valid;
    logic        stall_if;
    logic        stall_mem;
    logic        m_req;
    logic        m_we;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic [63:0] m_rdata;
    logic        m_ack;

    unified_mem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata),
        .m_ack     (m_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_if;
        bit          chk_data;
        logic [63:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_mis = 0;

    logic [63:0] mem_model [logic [63:0]];
    bit          auto_ack   = 1'b1;
    bit          inject_ack = 1'b0;
    int          ack_dly    = 1;
    int          ack_cnt    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic push_exp(input bit is_if, input bit chk_data, input logic [63:0] data);
        exp_t e;
        e.is_if    = is_if;
        e.chk_data = chk_data;
        e.data     = data;
        sb_q.push_back(e);
    endtask

    task automatic wait_valid(input bit want_if, input int bound, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            #1;
            if (want_if ? if_valid : mem_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 64'(seen), 64'd1);
    endtask

    // Memory model: acks after ack_dly cycles of m_req, commits stores on ack.
    always @(negedge clk) begin
        logic [63:0] key;
        m_ack = 1'b0;
        if (inject_ack) begin
            m_ack      = 1'b1;
            m_rdata    = 64'h0BAD_0BAD_0BAD_0BAD;
            inject_ack = 1'b0;
        end else if (auto_ack && m_req) begin
            ack_cnt++;
            if (ack_cnt >= ack_dly) begin
                key = m_addr >> 3;
                if (m_we) mem_model[key] = m_wdata;
                m_rdata = mem_model.exists(key) ? mem_model[key] : 64'h0;
                m_ack   = 1'b1;
                ack_cnt = 0;
            end
        end else begin
            ack_cnt = 0;
        end
    end

    // Monitor: every valid pulse pops and checks the oldest expected response.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (if_valid) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_if_valid", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("sb_owner_if", 64'd1, 64'(e.is_if));
                if (e.chk_data) check("sb_if_rdata", 64'(if_rdata), e.data);
            end
        end
        if (mem_valid) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_mem_valid", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("sb_owner_mem", 64'd0, 64'(e.is_if));
                if (e.chk_data) check("sb_mem_rdata", mem_rdata, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  stall_cnt;
        int  lat;
        int  n_mem;
        int  n_if;
        bit  done;
        bit  seen;

        reset     = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        m_rdata   = '0;
        m_ack     = 1'b0;
        mem_model[64'h20] = 64'hAAAA_BBBB_1111_2222;

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        check("rst_if_valid",  64'(if_valid),  64'd0);
        check("rst_mem_valid", 64'(mem_valid), 64'd0);
        check("rst_m_req",     64'(m_req),     64'd0);
        check("rst_m_we",      64'(m_we),      64'd0);
        check("rst_m_addr",    m_addr,         64'd0);
        check("rst_m_wdata",   m_wdata,        64'd0);
        check("rst_if_rdata",  64'(if_rdata),  64'd0);
        check("rst_mem_rdata", mem_rdata,      64'd0);
        check("rst_stall_if",  64'(stall_if),  64'd0);
        check("rst_stall_mem", 64'(stall_mem), 64'd0);
        reset = 1'b1;

        // Reset asserted mid-BUSY, then a late ack must be ignored
        auto_ack = 1'b0;
        @(negedge clk);
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 64'h300;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            if (m_req) begin
                seen = 1'b1;
                break;
            end
        end
        check("midbusy_m_req_up", 64'(seen), 64'd1);
        reset   = 1'b0;
        mem_req = 1'b0;
        #1;
        check("midbusy_rst_m_req", 64'(m_req),  64'd0);
        check("midbusy_rst_m_addr", m_addr,     64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        inject_ack = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (mem_valid || if_valid || m_req) seen = 1'b1;
        end
        check("late_ack_ignored", 64'(seen), 64'd0);
        auto_ack = 1'b1;

        // IF only fetch, upper half of the word
        ack_dly = 1;
        push_exp(1'b1, 1'b1, 64'h0000_0000_AAAA_BBBB);
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 64'h104;
        stall_cnt = 0;
        lat = 0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (if_valid) begin
                seen = 1'b1;
                break;
            end
            if (stall_if) stall_cnt++;
            if (lat == 1) begin
                check("if_m_req",  64'(m_req), 64'd1);
                check("if_m_we",   64'(m_we),  64'd0);
                check("if_m_addr", m_addr,     64'h104);
            end
            @(negedge clk);
            lat++;
        end
        if_req = 1'b0;
        check("if_valid_seen",   64'(seen),      64'd1);
        check("if_latency",      64'(lat),       64'd2);
        check("if_stall_cycles", 64'(stall_cnt), 64'd2);

        // MEM store with a 3-cycle ack
        ack_dly = 3;
        push_exp(1'b0, 1'b0, 64'h0);
        @(negedge clk);
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = 64'h200;
        mem_wdata = 64'hDEAD_BEEF_0000_0001;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("st_m_req",     64'(m_req),     64'd1);
            check("st_m_we",      64'(m_we),      64'd1);
            check("st_m_addr",    m_addr,         64'h200);
            check("st_m_wdata",   m_wdata,        64'hDEAD_BEEF_0000_0001);
            check("st_stall_mem", 64'(stall_mem), 64'd1);
            mem_wdata = 64'h1234_5678_9ABC_DEF0;
            mem_addr  = 64'h3F8;
            @(negedge clk);
        end
        #1;
        check("st_mem_valid", 64'(mem_valid), 64'd1);
        check("st_stall_mem_released", 64'(stall_mem), 64'd0);
        mem_req = 1'b0;
        mem_we  = 1'b0;

        // MEM load reads back the stored word
        ack_dly = 1;
        push_exp(1'b0, 1'b1, 64'hDEAD_BEEF_0000_0001);
        @(negedge clk);
        mem_req  = 1'b1;
        mem_addr = 64'h200;
        wait_valid(1'b0, 10, "ld_mem_valid");
        mem_req = 1'b0;

        // Both requesting together: MEM first, IF in the following IDLE cycle
        push_exp(1'b0, 1'b1, 64'hDEAD_BEEF_0000_0001);
        push_exp(1'b1, 1'b1, 64'h0000_0000_AAAA_BBBB);
        @(negedge clk);
        if_req   = 1'b1;
        if_addr  = 64'h104;
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 64'h200;
        wait_valid(1'b0, 10, "both_mem_valid");
        mem_req = 1'b0;
        @(negedge clk);
        #1;
        check("both_idle_gap_m_req", 64'(m_req), 64'd0);
        @(negedge clk);
        #1;
        check("both_if_granted_m_req", 64'(m_req),  64'd1);
        check("both_if_m_addr",        m_addr,      64'h104);
        check("both_if_m_we",          64'(m_we),   64'd0);
        wait_valid(1'b1, 10, "both_if_valid");
        if_req = 1'b0;

        // Continuous MEM traffic while IF waits
`ifdef ARB_STARVE_GUARD_EN
        for (int i = 0; i < 4; i++) push_exp(1'b0, 1'b1, 64'hDEAD_BEEF_0000_0001);
        push_exp(1'b1, 1'b1, 64'h0000_0000_AAAA_BBBB);
`else
        for (int i = 0; i < 6; i++) push_exp(1'b0, 1'b1, 64'hDEAD_BEEF_0000_0001);
`endif
        @(negedge clk);
        if_req   = 1'b1;
        if_addr  = 64'h104;
        mem_req  = 1'b1;
        mem_addr = 64'h200;
        n_mem = 0;
        n_if  = 0;
        done  = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            #1;
            if (mem_valid) n_mem++;
            if (if_valid) begin
                n_if++;
                done = 1'b1;
            end
`ifndef ARB_STARVE_GUARD_EN
            if (n_mem == 6) done = 1'b1;
`endif
        end
        if_req  = 1'b0;
        mem_req = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
        check("starve_mem_grants_before_if", 64'(n_mem), 64'd4);
        check("starve_if_granted",           64'(n_if),  64'd1);
`else
        check("strict_mem_grants", 64'(n_mem), 64'd6);
        check("strict_if_never",   64'(n_if),  64'd0);
`endif

        repeat (5) @(negedge clk);
        #3;
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
